// File: rtl/sad_param.sv
// sad_param: block SAD engine over paired input memories; `define SAD_MIN_TRACK_EN to add best-block tracking
module sad_param #(
  parameter int DATA_W     = 8,
  parameter int BLOCK_SIZE = 256,
  parameter int NUM_BLOCKS = 128,
  parameter int ADDR_W     = 15,
  parameter int C_ADDR_W   = 7,
  parameter int SUM_W      = 32
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Go,
  input  logic                Abort,
  input  logic [DATA_W-1:0]   A_Data,
  input  logic [DATA_W-1:0]   B_Data,
  output logic [ADDR_W-1:0]   A_Addr,
  output logic [ADDR_W-1:0]   B_Addr,
  output logic                I_En,
  output logic                I_RW,
  output logic [C_ADDR_W-1:0] C_Addr,
  output logic                O_En,
  output logic                O_RW,
  output logic [SUM_W-1:0]    SAD_Out,
  output logic                Busy,
  output logic                Done,
  output logic [SUM_W-1:0]    Min_SAD,
  output logic [C_ADDR_W-1:0] Min_Idx
);
  localparam int JW = $clog2(BLOCK_SIZE + 1);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  logic [2:0]          state;
  logic [JW-1:0]       j;
  logic [C_ADDR_W-1:0] k;
  logic [SUM_W-1:0]    sum;
  logic [DATA_W-1:0]   diff;
  logic [ADDR_W-1:0]   addr;
  logic                fetch_end;
  logic                last_blk;
  assign fetch_end = j == JW'(BLOCK_SIZE);
  assign last_blk  = k == C_ADDR_W'(NUM_BLOCKS - 1);
  assign diff      = A_Data > B_Data ? A_Data - B_Data : B_Data - A_Data;
  assign addr      = ADDR_W'(k) * ADDR_W'(BLOCK_SIZE) + ADDR_W'(j);
  // Outputs decode straight from state so an async reset clears them at once
  assign I_En    = state == S_FETCH && !fetch_end;
  assign I_RW    = 1'b0;
  assign A_Addr  = I_En ? addr : '0;
  assign B_Addr  = I_En ? addr : '0;
  assign O_En    = state == S_WRITE;
  assign O_RW    = O_En;
  assign C_Addr  = O_En ? k : '0;
  assign SAD_Out = O_En ? sum : '0;
  assign Busy    = state != S_IDLE;
  assign Done    = state == S_DONE;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      j     <= '0;
      k     <= '0;
      sum   <= '0;
    end else if (Abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (Go) begin
          state <= S_INIT;
          k     <= '0;
        end
        S_INIT: begin
          sum   <= '0;
          j     <= '0;
          state <= S_FETCH;
        end
        S_FETCH: state <= fetch_end ? S_WRITE : S_WAIT;
        S_WAIT:  state <= S_ACC;
        S_ACC: begin
          sum   <= sum + SUM_W'(diff);
          j     <= j + 1'b1;
          state <= S_FETCH;
        end
        S_WRITE: begin
          state <= last_blk ? S_DONE : S_INIT;
          if (!last_blk) k <= k + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef SAD_MIN_TRACK_EN
  // Updates even when Abort coincides with WRITE, since that write still lands
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Min_SAD <= '0;
      Min_Idx <= '0;
    end else if (state == S_WRITE && (k == '0 || sum < Min_SAD)) begin
      Min_SAD <= sum;
      Min_Idx <= k;
    end
  end
`else
  assign Min_SAD = '0;
  assign Min_Idx = '0;
`endif
endmodule

// File: tb/tb_sad_param.sv
// tb_sad_param: scoreboard bench for sad_param at DATA_W=8, BLOCK_SIZE=4, NUM_BLOCKS=2
module tb_sad_param;
  localparam int DW = 8;
  localparam int BS = 4;
  localparam int NB = 2;
  localparam int AW = 3;
  localparam int CW = 1;
  localparam int SW = 16;
  logic          Clk = 0, Rst_n = 0, Go = 0, Abort = 0;
  logic [DW-1:0] A_Data = '0, B_Data = '0;
  logic [AW-1:0] A_Addr, B_Addr;
  logic          I_En, I_RW, O_En, O_RW, Busy, Done;
  logic [CW-1:0] C_Addr, Min_Idx;
  logic [SW-1:0] SAD_Out, Min_SAD;
  logic [DW-1:0] a_mem [BS*NB];
  logic [DW-1:0] b_mem [BS*NB];
  int total = 0, bad = 0, done_cnt = 0, fetch_idx = 0;
  int exp_q[$], exp_addr_q[$];
  int exp_min = 0, exp_idx = 0;
  int cyc, d0;

  sad_param #(.DATA_W(DW), .BLOCK_SIZE(BS), .NUM_BLOCKS(NB), .ADDR_W(AW),
              .C_ADDR_W(CW), .SUM_W(SW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Go(Go), .Abort(Abort), .A_Data(A_Data), .B_Data(B_Data),
    .A_Addr(A_Addr), .B_Addr(B_Addr), .I_En(I_En), .I_RW(I_RW), .C_Addr(C_Addr),
    .O_En(O_En), .O_RW(O_RW), .SAD_Out(SAD_Out), .Busy(Busy), .Done(Done),
    .Min_SAD(Min_SAD), .Min_Idx(Min_Idx));

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (I_En) begin
    A_Data <= a_mem[A_Addr];
    B_Data <= b_mem[B_Addr];
  end

  task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge Clk) if (Rst_n) begin
    check("rw_strobes", {I_RW, O_RW}, {1'b0, O_En});
    if (I_En) begin
      check("a_addr", A_Addr, fetch_idx % (BS * NB));
      check("b_addr", B_Addr, fetch_idx % (BS * NB));
      fetch_idx++;
    end else check("addr_idle", {A_Addr, B_Addr}, 0);
    if (O_En) begin
      check("write_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check("sad", SAD_Out, exp_q.pop_front());
        check("c_addr", C_Addr, exp_addr_q.pop_front());
      end
    end else check("out_idle", {C_Addr, SAD_Out}, 0);
    if (Done) done_cnt++;
  end

  task set_mem(input int a0, input int b0, input int a1, input int b1);
    for (int i = 0; i < BS; i++) begin
      a_mem[i] = DW'(a0); b_mem[i] = DW'(b0);
      a_mem[BS+i] = DW'(a1); b_mem[BS+i] = DW'(b1);
    end
  endtask

  task push_run();
    for (int k = 0; k < NB; k++) begin
      int s;
      s = 0;
      for (int j = 0; j < BS; j++)
        s += a_mem[k*BS+j] > b_mem[k*BS+j] ? a_mem[k*BS+j] - b_mem[k*BS+j] : b_mem[k*BS+j] - a_mem[k*BS+j];
      exp_q.push_back(s);
      exp_addr_q.push_back(k);
`ifdef SAD_MIN_TRACK_EN
      if (k == 0 || s < exp_min) begin
        exp_min = s;
        exp_idx = k;
      end
`endif
    end
  endtask

  task wait_done(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Done && n < 500);
    check("done_seen", Done, 1);
  endtask

  task pulse_go();
    push_run();
    fetch_idx = 0;
    @(negedge Clk);
    Go = 1;
    @(posedge Clk);
    #1 Go = 0;
  endtask

  task run(input string tag);
    pulse_go();
    wait_done(cyc);
    check({tag, "_latency"}, cyc, 31);
    @(negedge Clk);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_idle"}, Busy, 0);
    check({tag, "_min_sad"}, Min_SAD, exp_min);
    check({tag, "_min_idx"}, Min_Idx, exp_idx);
  endtask

  initial begin
    #12;
    check("reset_outs", {A_Addr, B_Addr, I_En, I_RW, C_Addr, O_En, O_RW, SAD_Out, Busy, Done, Min_SAD, Min_Idx}, 0);
    @(negedge Clk) Rst_n = 1;
    set_mem(10, 3, 10, 3);    run("basic");
    set_mem(0, 255, 0, 255);  run("maxmag");
    set_mem(77, 77, 77, 77);  run("equal");
    set_mem(0, 10, 3, 0);     run("min_second");
    set_mem(5, 9, 9, 5);      run("min_tie");
    for (int i = 0; i < BS * NB; i++) begin
      a_mem[i] = DW'($urandom_range(0, 255));
      b_mem[i] = DW'($urandom_range(0, 255));
    end
    run("random");
    // Abort ten cycles into a run, well before the first WRITE
    set_mem(10, 3, 10, 3);
    pulse_go();
    repeat (10) @(negedge Clk);
    Abort = 1;
    d0 = done_cnt;
    @(posedge Clk);
    #1 Abort = 0;
    exp_q.delete();
    exp_addr_q.delete();
    check("abort_idle", Busy, 0);
    repeat (40) @(negedge Clk);
    check("abort_no_done", done_cnt, d0);
    run("after_abort");
    // Asynchronous reset in the middle of the first ACC cycle
    set_mem(0, 255, 10, 3);
    pulse_go();
    repeat (4) @(negedge Clk);
    #2 Rst_n = 0;
    #1;
    check("midrun_reset_outs", {A_Addr, B_Addr, I_En, I_RW, C_Addr, O_En, O_RW, SAD_Out, Busy, Done, Min_SAD, Min_Idx}, 0);
    exp_q.delete();
    exp_addr_q.delete();
    d0 = done_cnt;
    @(negedge Clk) Rst_n = 1;
    repeat (3) @(negedge Clk);
    check("reset_no_done", done_cnt, d0);
    run("after_reset");
    // Go held high: exactly one IDLE cycle between back-to-back runs
    set_mem(20, 1, 4, 6);
    push_run();
    push_run();
    fetch_idx = 0;
    @(negedge Clk);
    Go = 1;
    wait_done(cyc);
    check("held_latency1", cyc, 31);
    @(negedge Clk);
    check("held_gap_idle", Busy, 0);
    @(negedge Clk);
    check("held_restart", Busy, 1);
    wait_done(cyc);
    check("held_latency2", cyc, 30);
    Go = 0;
    @(negedge Clk);
    check("held_sb_empty", exp_q.size(), 0);
    check("held_idle", Busy, 0);
    check("held_min_sad", Min_SAD, exp_min);
    repeat (5) @(negedge Clk);
    check("held_stays_idle", Busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sad_param.md
SAD_PARAM -- requirements
Module: sad_param

Interface
REQ-001 Parameter DATA_W, default 8: unsigned pixel width.
REQ-002 Parameter BLOCK_SIZE, default 256: elements per block, at least 1.
REQ-003 Parameter NUM_BLOCKS, default 128: blocks per frame, at least 1.
REQ-004 Parameter ADDR_W, default 15: input address width; ADDR_W >= clog2(BLOCK_SIZE*NUM_BLOCKS) SHALL hold.
REQ-005 Parameter C_ADDR_W, default 7: output address width; C_ADDR_W >= clog2(NUM_BLOCKS) SHALL hold.
REQ-006 Parameter SUM_W, default 32: SAD width; SUM_W >= DATA_W+clog2(BLOCK_SIZE)+1 SHALL hold, so no overflow is possible.
REQ-007 Clk  in  1: rising-edge clock.
REQ-008 Rst_n  in  1: reset, asynchronous, active-low.
REQ-009 Go  in  1: start; sampled only in IDLE.
REQ-010 Abort  in  1: cancel the run in progress.
REQ-011 A_Data, B_Data  in  DATA_W: input-memory read data.
REQ-012 A_Addr, B_Addr  out  ADDR_W: input-memory addresses.
REQ-013 I_En, I_RW  out  1: input-memory enable; I_RW is always 0 (read).
REQ-014 C_Addr  out  C_ADDR_W: output-memory address, equal to the block index.
REQ-015 O_En, O_RW  out  1: output-memory write strobe; O_RW is 1 whenever O_En is 1.
REQ-016 SAD_Out  out  SUM_W: block SAD, valid only while O_En is 1, else 0.
REQ-017 Busy  out  1: high in every state except IDLE.
REQ-018 Done  out  1: one-cycle completion pulse.
REQ-019 Min_SAD  out  SUM_W, Min_Idx  out  C_ADDR_W: best block result (see REQ-033).

Function
REQ-020 The FSM SHALL have states IDLE, INIT, FETCH, WAIT, ACC, WRITE, DONE.
REQ-021 IDLE: Go=1 moves to INIT and clears block index K; Go=0 stays in IDLE.
REQ-022 INIT: Sum<=0, element index J<=0, then FETCH.
REQ-023 FETCH with J<BLOCK_SIZE: drive A_Addr=B_Addr=K*BLOCK_SIZE+J, I_En=1 for exactly this cycle, then WAIT.
REQ-024 FETCH with J==BLOCK_SIZE: go to WRITE with no memory access.
REQ-025 WAIT: one idle cycle, then ACC; read data is valid during ACC.
REQ-026 ACC: Sum<=Sum+|A_Data-B_Data| (unsigned, DATA_W-bit magnitude), J<=J+1, then FETCH.
REQ-027 WRITE: O_En=O_RW=1, C_Addr=K, SAD_Out=Sum, for one cycle.
REQ-028 WRITE exit: if K==NUM_BLOCKS-1 go to DONE, else K<=K+1 and go to INIT.
REQ-029 DONE: Done=1 for one cycle, then IDLE.
REQ-030 Total latency from the edge sampling Go to the Done cycle SHALL be NUM_BLOCKS*(3*BLOCK_SIZE+3)+1 cycles.
REQ-031 Every strobe and address output not explicitly driven in a state SHALL be 0 in that cycle.
REQ-032 Abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with no Done; a WRITE in that same cycle still completes; Abort has priority over Go. Go while Busy SHALL be ignored.
REQ-033 Min tracking: in WRITE, if K==0 or Sum<Min_SAD, then Min_SAD<=Sum and Min_Idx<=K; ties keep the earlier index; values hold after Done until the next Go.

Reset
REQ-034 Rst_n=0 SHALL immediately force state IDLE and set every output, Sum, J and K to 0, including in the middle of a run; no Done is generated for the interrupted run.

Configuration
REQ-035 Macro SAD_MIN_TRACK_EN: when defined, REQ-033 logic SHALL be built; when undefined, Min_SAD and Min_Idx SHALL be constant 0 with no comparator, and all other timing SHALL be unchanged.

Verification (DATA_W=8, BLOCK_SIZE=4, NUM_BLOCKS=2)
REQ-036 A=10,B=3 at every address; pulse Go -> writes to C_Addr 0 and 1 with SAD_Out=28; Done 31 cycles after Go.
REQ-037 A=0,B=255 at every address -> SAD_Out=1020 (max magnitude, no overflow); A=B -> SAD_Out=0.
REQ-038 With SAD_MIN_TRACK_EN: block0 SAD=40, block1 SAD=12 -> Min_SAD=12, Min_Idx=1; with equal SADs -> Min_Idx=0.
REQ-039 Abort at cycle 10 of a run -> IDLE next cycle, no WRITE for block 1, no Done; a new Go then completes normally.
REQ-040 Rst_n low mid-ACC, asynchronous to Clk -> all outputs 0 immediately; Go after release gives a fresh, correct run.
REQ-041 Go held high throughout a run -> no restart while Busy; a second run starts from IDLE right after Done.
